mem_port_arbiter: RTL and testbench
===================================

# mem_port_arbiter

Shares one SRAM-like memory port between the IF-stage instruction-fetch requester and the EX-stage data requester of the dual-issue core. It buffers one granted request toward memory, tracks up to OUTSTANDING in-order transactions in a source-tag FIFO, and routes each response back to its originator. It sits between IfStage/ExStage and the external memory bridge. On `excep_flush_i` it discards the responses of in-flight instruction fetches.

## Interface
- OUTSTANDING, 4: max transactions in buffer + FIFO; power of 2, ≥2
- STARVE_LIMIT, 3: consecutive data grants allowed while inst waits before inst is forced
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- excep_flush_i  in  1  WB exception flush pulse
- inst_req_i / inst_addr_i  in  1 / 32  fetch request (read only)
- inst_addr_ok_o  out  1  fetch request accepted this cycle
- inst_data_ok_o / inst_rdata_o  out  1 / 32  fetch response
- data_req_i / data_wr_i / data_wstrb_i / data_addr_i / data_wdata_i  in  1/1/4/32/32  data request
- data_addr_ok_o  out  1  data request accepted this cycle
- data_data_ok_o / data_rdata_o  out  1 / 32  data response (writes get data_ok too)
- mem_req_o / mem_wr_o / mem_wstrb_o / mem_addr_o / mem_wdata_o  out  1/1/4/32/32  shared port request, all registered
- mem_addr_ok_i  in  1  memory accepted mem_req_o
- mem_data_ok_i / mem_rdata_i  in  1 / 32  in-order memory response
- err_o  out  1  sticky: mem_data_ok_i seen with the FIFO empty

## Operation
- Request buffer (`rb`): valid, src (0=inst, 1=data), cancel, wr, wstrb, addr, wdata. It drives mem_* directly. mem_req_o = rb.valid.
- Tag FIFO: entries {src, cancel}, depth OUTSTANDING. Push {rb.src, rb.cancel} on mem_req_o & mem_addr_ok_i. Pop on mem_data_ok_i.
- occ = FIFO count + rb.valid. Credit = occ < OUTSTANDING. Same-cycle pops do not add credit.
- Slot free = !rb.valid | mem_addr_ok_i.
- Accept when slot free & credit & a request is pending. Selection:
  - data wins over inst by default;
  - inst is forced when streak == STARVE_LIMIT & inst_req_i.
- Exactly one of inst_addr_ok_o / data_addr_ok_o is asserted per accept, combinationally in the same cycle as the accept.
- On accept, rb loads the winner's fields next edge; inst loads wr=0, wstrb=0, wdata=0.
- Streak counter:
  - +1, saturating at STARVE_LIMIT, on a data grant while inst_req_i is high;
  - cleared on an inst grant, or when inst_req_i is low.
- Response routing (combinational), based on head = FIFO head:
  - inst_data_ok_o = mem_data_ok_i & !head.src & !head.cancel;
  - data_data_ok_o = mem_data_ok_i & head.src;
  - both rdata outputs = mem_rdata_i.
- Flush: excep_flush_i sets cancel on every FIFO entry with src=0 and on rb if rb.src=0.
  - A cancelled rb still issues to memory; a request cannot be withdrawn once presented.
  - No inst accept happens in the flush cycle. Data accepts continue.
  - Data entries are never cancelled.
- Empty FIFO & mem_data_ok_i: set err_o, pop nothing, assert no data_ok.
- Invariants:
  - rb fields are stable while mem_req_o & !mem_addr_ok_i;
  - responses return to requesters in issue order.

## Timing
- Reset values: rb.valid=0, FIFO empty, streak=0, err_o=0.
  - Outputs: mem_req_o=0 and all mem_* = 0; all addr_ok/data_ok = 0; rdata follows mem_rdata_i.
- Accept-to-mem_req_o latency is 1 cycle. With mem_addr_ok_i held high, one accept per cycle is sustained (back-to-back).
- Response latency through the arbiter is 0 cycles (combinational).
- Simultaneous events:
  - mem_addr_ok_i and a new accept in the same cycle: rb reloads without a bubble.
  - Push and pop in the same cycle: count unchanged.
  - A push with flush in the same cycle of an inst rb: the entry is pushed with cancel=1.
- Credit full (occ == OUTSTANDING): both addr_ok outputs stay 0 until occ drops on a later cycle.
- FIFO pointers are log2(OUTSTANDING) bits and wrap naturally. The count is log2+1 bits.
- rst_n low mid-transaction clears all state immediately. Responses arriving after reset hit an empty FIFO and set err_o.

## Test plan
- Single inst read at 0x1C00_0000, memory addr_ok same cycle, data_ok 2 cycles later with 0x0280_0000
  -> inst_addr_ok_o in cycle 0, mem_req_o in cycle 1, inst_data_ok_o with rdata 0x0280_0000 in cycle 3, data_data_ok_o never asserted.
- inst_req_i and data_req_i both held high continuously, memory always ready, STARVE_LIMIT=3
  -> grant order D,D,D,I,D,D,D,I; responses routed correctly; err_o stays 0.
- mem_addr_ok_i tied low with both requesters active
  -> exactly one accept, rb stable indefinitely, no further addr_ok.
  - Then release with 4 outstanding and data_ok withheld -> accepts stop at occ=4; the first data_ok allows one new accept the following cycle.
- Issue inst A, data B, inst C; pulse excep_flush_i before any response; return 3 responses
  -> only data_data_ok_o fires (for B); inst_data_ok_o stays 0; FIFO empty afterwards.
- Data write with wstrb=4'b0011, addr 0x0000_1000, wdata 0xDEAD_BEEF
  -> mem_wr_o=1 with all fields exact while stalled 3 cycles on addr_ok; data_data_ok_o on the write response.
- mem_data_ok_i with the FIFO empty; then rst_n pulsed low mid-transaction
  -> err_o=1 and stays 1; after reset all outputs return to their reset values asynchronously.

Source files
------------

// File: rtl/mem_port_arbiter_if.sv
// rtl/mem_port_arbiter_if.sv - fetch, data and memory-side signals of the shared memory port
interface mem_port_arbiter_if;
  logic        excep_flush_i;
  logic        inst_req_i;
  logic [31:0] inst_addr_i;
  logic        inst_addr_ok_o;
  logic        inst_data_ok_o;
  logic [31:0] inst_rdata_o;
  logic        data_req_i;
  logic        data_wr_i;
  logic [3:0]  data_wstrb_i;
  logic [31:0] data_addr_i;
  logic [31:0] data_wdata_i;
  logic        data_addr_ok_o;
  logic        data_data_ok_o;
  logic [31:0] data_rdata_o;
  logic        mem_req_o;
  logic        mem_wr_o;
  logic [3:0]  mem_wstrb_o;
  logic [31:0] mem_addr_o;
  logic [31:0] mem_wdata_o;
  logic        mem_addr_ok_i;
  logic        mem_data_ok_i;
  logic [31:0] mem_rdata_i;
  logic        err_o;

  modport slave (
    input  excep_flush_i, inst_req_i, inst_addr_i,
    input  data_req_i, data_wr_i, data_wstrb_i, data_addr_i, data_wdata_i,
    input  mem_addr_ok_i, mem_data_ok_i, mem_rdata_i,
    output inst_addr_ok_o, inst_data_ok_o, inst_rdata_o,
    output data_addr_ok_o, data_data_ok_o, data_rdata_o,
    output mem_req_o, mem_wr_o, mem_wstrb_o, mem_addr_o, mem_wdata_o, err_o
  );

  modport master (
    output excep_flush_i, inst_req_i, inst_addr_i,
    output data_req_i, data_wr_i, data_wstrb_i, data_addr_i, data_wdata_i,
    output mem_addr_ok_i, mem_data_ok_i, mem_rdata_i,
    input  inst_addr_ok_o, inst_data_ok_o, inst_rdata_o,
    input  data_addr_ok_o, data_data_ok_o, data_rdata_o,
    input  mem_req_o, mem_wr_o, mem_wstrb_o, mem_addr_o, mem_wdata_o, err_o
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - shares one memory port between fetch and data, routes in-order responses by tag
module mem_port_arbiter #(
  parameter int OUTSTANDING  = 4,
  parameter int STARVE_LIMIT = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  mem_port_arbiter_if.slave bus
);
  localparam int PW = $clog2(OUTSTANDING);
  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam logic [PW:0]   DEPTH      = (PW + 1)'(OUTSTANDING);
  localparam logic [SW-1:0] STREAK_MAX = SW'(STARVE_LIMIT);

  logic                   rb_valid_q, rb_valid_d;
  logic                   rb_src_q, rb_src_d;
  logic                   rb_cancel_q, rb_cancel_d;
  logic                   rb_wr_q, rb_wr_d;
  logic [3:0]             rb_wstrb_q, rb_wstrb_d;
  logic [31:0]            rb_addr_q, rb_addr_d;
  logic [31:0]            rb_wdata_q, rb_wdata_d;
  logic [OUTSTANDING-1:0] fifo_src_q, fifo_src_d;
  logic [OUTSTANDING-1:0] fifo_cancel_q, fifo_cancel_d;
  logic [PW-1:0]          wptr_q, wptr_d;
  logic [PW-1:0]          rptr_q, rptr_d;
  logic [PW:0]            count_q, count_d;
  logic [SW-1:0]          streak_q, streak_d;
  logic                   err_q, err_d;

  logic        push, pop, fifo_empty, head_src, head_cancel;
  logic        credit, slot_free, can_accept, force_inst;
  logic        grant_inst, grant_data;
  logic [PW:0] occ;

  assign fifo_empty  = (count_q == '0);
  assign push        = rb_valid_q & bus.mem_addr_ok_i;
  assign pop         = bus.mem_data_ok_i & !fifo_empty;
  assign head_src    = fifo_src_q[rptr_q];
  assign head_cancel = fifo_cancel_q[rptr_q];

  // Credit is judged on registered occupancy only, so a response popping this cycle frees a slot next cycle.
  assign occ        = count_q + {{PW{1'b0}}, rb_valid_q};
  assign credit     = (occ < DEPTH);
  assign slot_free  = !rb_valid_q | bus.mem_addr_ok_i;
  assign can_accept = slot_free & credit;
  assign force_inst = (streak_q == STREAK_MAX) & bus.inst_req_i;

  // A flushed cycle never takes a fetch; its address belongs to the squashed path.
  assign grant_inst = can_accept & bus.inst_req_i & !bus.excep_flush_i
                    & (force_inst | !bus.data_req_i);
  assign grant_data = can_accept & bus.data_req_i & !grant_inst;

  always_comb begin
    rb_valid_d    = rb_valid_q;
    rb_src_d      = rb_src_q;
    rb_cancel_d   = rb_cancel_q;
    rb_wr_d       = rb_wr_q;
    rb_wstrb_d    = rb_wstrb_q;
    rb_addr_d     = rb_addr_q;
    rb_wdata_d    = rb_wdata_q;
    fifo_src_d    = fifo_src_q;
    fifo_cancel_d = fifo_cancel_q | ({OUTSTANDING{bus.excep_flush_i}} & ~fifo_src_q);
    wptr_d        = wptr_q;
    rptr_d        = rptr_q;
    count_d       = count_q;
    streak_d      = streak_q;
    err_d         = err_q | (bus.mem_data_ok_i & fifo_empty);

    if (grant_inst | grant_data) begin
      rb_valid_d  = 1'b1;
      rb_src_d    = grant_data;
      rb_cancel_d = 1'b0;
      rb_wr_d     = grant_data & bus.data_wr_i;
      rb_wstrb_d  = grant_data ? bus.data_wstrb_i : 4'b0000;
      rb_addr_d   = grant_data ? bus.data_addr_i : bus.inst_addr_i;
      rb_wdata_d  = grant_data ? bus.data_wdata_i : 32'h0;
    end else begin
      if (push) rb_valid_d = 1'b0;
      if (bus.excep_flush_i & !rb_src_q) rb_cancel_d = 1'b1;
    end

    if (push) begin
      fifo_src_d[wptr_q]    = rb_src_q;
      fifo_cancel_d[wptr_q] = rb_cancel_q | (bus.excep_flush_i & !rb_src_q);
      wptr_d                = wptr_q + 1'b1;
    end
    if (pop) rptr_d = rptr_q + 1'b1;

    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase

    if (grant_data & bus.inst_req_i)
      streak_d = (streak_q == STREAK_MAX) ? STREAK_MAX : streak_q + 1'b1;
    else if (grant_inst | !bus.inst_req_i)
      streak_d = '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rb_valid_q    <= 1'b0;
      rb_src_q      <= 1'b0;
      rb_cancel_q   <= 1'b0;
      rb_wr_q       <= 1'b0;
      rb_wstrb_q    <= 4'b0000;
      rb_addr_q     <= 32'h0;
      rb_wdata_q    <= 32'h0;
      fifo_src_q    <= '0;
      fifo_cancel_q <= '0;
      wptr_q        <= '0;
      rptr_q        <= '0;
      count_q       <= '0;
      streak_q      <= '0;
      err_q         <= 1'b0;
    end else begin
      rb_valid_q    <= rb_valid_d;
      rb_src_q      <= rb_src_d;
      rb_cancel_q   <= rb_cancel_d;
      rb_wr_q       <= rb_wr_d;
      rb_wstrb_q    <= rb_wstrb_d;
      rb_addr_q     <= rb_addr_d;
      rb_wdata_q    <= rb_wdata_d;
      fifo_src_q    <= fifo_src_d;
      fifo_cancel_q <= fifo_cancel_d;
      wptr_q        <= wptr_d;
      rptr_q        <= rptr_d;
      count_q       <= count_d;
      streak_q      <= streak_d;
      err_q         <= err_d;
    end
  end

  assign bus.mem_req_o      = rb_valid_q;
  assign bus.mem_wr_o       = rb_wr_q;
  assign bus.mem_wstrb_o    = rb_wstrb_q;
  assign bus.mem_addr_o     = rb_addr_q;
  assign bus.mem_wdata_o    = rb_wdata_q;
  assign bus.inst_addr_ok_o = grant_inst;
  assign bus.data_addr_ok_o = grant_data;
  assign bus.inst_data_ok_o = pop & !head_src & !head_cancel;
  assign bus.data_data_ok_o = pop & head_src;
  assign bus.inst_rdata_o   = bus.mem_rdata_i;
  assign bus.data_rdata_o   = bus.mem_rdata_i;
  assign bus.err_o          = err_q;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - directed self-checking bench for mem_port_arbiter
module tb_mem_port_arbiter;
  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  mem_port_arbiter_if bus ();

  mem_port_arbiter #(.OUTSTANDING(4), .STARVE_LIMIT(3)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #3;
  endtask

  task automatic idle();
    bus.excep_flush_i = 1'b0;
    bus.inst_req_i    = 1'b0;
    bus.inst_addr_i   = 32'h0;
    bus.data_req_i    = 1'b0;
    bus.data_wr_i     = 1'b0;
    bus.data_wstrb_i  = 4'h0;
    bus.data_addr_i   = 32'h0;
    bus.data_wdata_i  = 32'h0;
    bus.mem_addr_ok_i = 1'b0;
    bus.mem_data_ok_i = 1'b0;
    bus.mem_rdata_i   = 32'h0;
  endtask

  task automatic test_reset();
    idle();
    bus.mem_rdata_i = 32'h1234_5678;
    rst_n = 1'b0;
    step(); step(); settle();
    checks++; if ({bus.mem_req_o, bus.mem_wr_o, bus.mem_wstrb_o} !== 6'h0) begin errors++; $display("FAIL reset_mem_ctl got %h want 0", {bus.mem_req_o, bus.mem_wr_o, bus.mem_wstrb_o}); end
    checks++; if (bus.mem_addr_o !== 32'h0) begin errors++; $display("FAIL reset_mem_addr got %h want 0", bus.mem_addr_o); end
    checks++; if (bus.mem_wdata_o !== 32'h0) begin errors++; $display("FAIL reset_mem_wdata got %h want 0", bus.mem_wdata_o); end
    checks++; if ({bus.inst_addr_ok_o, bus.data_addr_ok_o, bus.inst_data_ok_o, bus.data_data_ok_o, bus.err_o} !== 5'b0) begin errors++; $display("FAIL reset_flags got %b want 00000", {bus.inst_addr_ok_o, bus.data_addr_ok_o, bus.inst_data_ok_o, bus.data_data_ok_o, bus.err_o}); end
    checks++; if (bus.inst_rdata_o !== 32'h1234_5678) begin errors++; $display("FAIL reset_inst_rdata got %h want 12345678", bus.inst_rdata_o); end
    checks++; if (bus.data_rdata_o !== 32'h1234_5678) begin errors++; $display("FAIL reset_data_rdata got %h want 12345678", bus.data_rdata_o); end
    step();
    rst_n = 1'b1;
    bus.mem_rdata_i = 32'h0;
  endtask

  task automatic test_single_inst();
    step();
    bus.inst_req_i = 1'b1; bus.inst_addr_i = 32'h1C00_0000; bus.mem_addr_ok_i = 1'b1;
    settle();
    checks++; if ({bus.inst_addr_ok_o, bus.data_addr_ok_o, bus.mem_req_o} !== 3'b100) begin errors++; $display("FAIL single_c0 got %b want 100", {bus.inst_addr_ok_o, bus.data_addr_ok_o, bus.mem_req_o}); end
    step();
    bus.inst_req_i = 1'b0;
    settle();
    checks++; if ({bus.mem_req_o, bus.mem_wr_o, bus.mem_wstrb_o} !== 6'b10_0000) begin errors++; $display("FAIL single_c1_ctl got %b want 100000", {bus.mem_req_o, bus.mem_wr_o, bus.mem_wstrb_o}); end
    checks++; if (bus.mem_addr_o !== 32'h1C00_0000) begin errors++; $display("FAIL single_c1_addr got %h want 1c000000", bus.mem_addr_o); end
    step(); settle();
    checks++; if (bus.mem_req_o !== 1'b0) begin errors++; $display("FAIL single_c2_req got %b want 0", bus.mem_req_o); end
    step();
    bus.mem_data_ok_i = 1'b1; bus.mem_rdata_i = 32'h0280_0000;
    settle();
    checks++; if ({bus.inst_data_ok_o, bus.data_data_ok_o} !== 2'b10) begin errors++; $display("FAIL single_c3_ok got %b want 10", {bus.inst_data_ok_o, bus.data_data_ok_o}); end
    checks++; if (bus.inst_rdata_o !== 32'h0280_0000) begin errors++; $display("FAIL single_c3_rdata got %h want 02800000", bus.inst_rdata_o); end
    step();
    idle();
  endtask

  task automatic test_starvation();
    logic [7:0] exp_inst;
    exp_inst = 8'b1000_1000;
    for (int c = 0; c < 10; c++) begin
      step();
      bus.mem_addr_ok_i = 1'b1;
      bus.inst_req_i    = (c < 8);
      bus.data_req_i    = (c < 8);
      bus.inst_addr_i   = 32'h0000_0100 + c;
      bus.data_addr_i   = 32'h0000_0200 + c;
      bus.mem_data_ok_i = (c >= 2);
      bus.mem_rdata_i   = 32'hA000_0000 + c;
      settle();
      if (c < 8) begin
        checks++; if ({bus.inst_addr_ok_o, bus.data_addr_ok_o} !== {exp_inst[c], !exp_inst[c]}) begin errors++; $display("FAIL starve_grant c%0d got %b want %b", c, {bus.inst_addr_ok_o, bus.data_addr_ok_o}, {exp_inst[c], !exp_inst[c]}); end
      end else begin
        checks++; if ({bus.inst_addr_ok_o, bus.data_addr_ok_o} !== 2'b00) begin errors++; $display("FAIL starve_idle c%0d got %b want 00", c, {bus.inst_addr_ok_o, bus.data_addr_ok_o}); end
      end
      if (c >= 2) begin
        checks++; if ({bus.inst_data_ok_o, bus.data_data_ok_o} !== {exp_inst[c-2], !exp_inst[c-2]}) begin errors++; $display("FAIL starve_resp c%0d got %b want %b", c, {bus.inst_data_ok_o, bus.data_data_ok_o}, {exp_inst[c-2], !exp_inst[c-2]}); end
      end
    end
    step();
    idle();
    settle();
    checks++; if (bus.err_o !== 1'b0) begin errors++; $display("FAIL starve_err got %b want 0", bus.err_o); end
  endtask

  task automatic test_stall_and_credit();
    logic [1:0] g    [0:10];
    logic [1:0] resp [0:10];
    g    = '{2'b01, 2'b01, 2'b10, 2'b00, 2'b00, 2'b00, 2'b01, 2'b00, 2'b00, 2'b00, 2'b00};
    resp = '{2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b01, 2'b00, 2'b01, 2'b01, 2'b10, 2'b01};
    step();
    bus.inst_req_i = 1'b1; bus.inst_addr_i = 32'h0000_00B0;
    bus.data_req_i = 1'b1; bus.data_addr_i = 32'h0000_00A0;
    settle();
    checks++; if ({bus.inst_addr_ok_o, bus.data_addr_ok_o} !== 2'b01) begin errors++; $display("FAIL stall_first got %b want 01", {bus.inst_addr_ok_o, bus.data_addr_ok_o}); end
    for (int k = 1; k <= 4; k++) begin
      step();
      bus.data_addr_i = 32'hFFFF_0000 + k;
      settle();
      checks++; if ({bus.inst_addr_ok_o, bus.data_addr_ok_o, bus.mem_req_o} !== 3'b001) begin errors++; $display("FAIL stall_hold k%0d got %b want 001", k, {bus.inst_addr_ok_o, bus.data_addr_ok_o, bus.mem_req_o}); end
      checks++; if (bus.mem_addr_o !== 32'h0000_00A0) begin errors++; $display("FAIL stall_addr k%0d got %h want 000000a0", k, bus.mem_addr_o); end
    end
    for (int r = 0; r <= 10; r++) begin
      step();
      bus.mem_addr_ok_i = 1'b1;
      bus.inst_req_i    = (r <= 6);
      bus.data_req_i    = (r <= 6);
      bus.mem_data_ok_i = (r == 5) || (r >= 7);
      settle();
      checks++; if ({bus.inst_addr_ok_o, bus.data_addr_ok_o} !== g[r]) begin errors++; $display("FAIL credit_grant r%0d got %b want %b", r, {bus.inst_addr_ok_o, bus.data_addr_ok_o}, g[r]); end
      checks++; if ({bus.inst_data_ok_o, bus.data_data_ok_o} !== resp[r]) begin errors++; $display("FAIL credit_resp r%0d got %b want %b", r, {bus.inst_data_ok_o, bus.data_data_ok_o}, resp[r]); end
    end
    step();
    idle();
  endtask

  task automatic test_flush();
    step();
    bus.mem_addr_ok_i = 1'b1;
    bus.inst_req_i = 1'b1; bus.inst_addr_i = 32'h0000_3000;
    settle();
    checks++; if (bus.inst_addr_ok_o !== 1'b1) begin errors++; $display("FAIL flush_issue_a got %b want 1", bus.inst_addr_ok_o); end
    step();
    bus.inst_req_i = 1'b0;
    bus.data_req_i = 1'b1; bus.data_addr_i = 32'h0000_4000;
    settle();
    checks++; if (bus.data_addr_ok_o !== 1'b1) begin errors++; $display("FAIL flush_issue_b got %b want 1", bus.data_addr_ok_o); end
    step();
    bus.data_req_i = 1'b0;
    bus.inst_req_i = 1'b1; bus.inst_addr_i = 32'h0000_3004;
    settle();
    checks++; if (bus.inst_addr_ok_o !== 1'b1) begin errors++; $display("FAIL flush_issue_c got %b want 1", bus.inst_addr_ok_o); end
    step();
    bus.inst_addr_i = 32'h0000_3008;
    bus.excep_flush_i = 1'b1;
    settle();
    checks++; if ({bus.inst_addr_ok_o, bus.mem_req_o} !== 2'b01) begin errors++; $display("FAIL flush_cycle got %b want 01", {bus.inst_addr_ok_o, bus.mem_req_o}); end
    for (int k = 0; k < 3; k++) begin
      step();
      bus.excep_flush_i = 1'b0;
      bus.inst_req_i    = 1'b0;
      bus.mem_data_ok_i = 1'b1;
      settle();
      checks++; if ({bus.inst_data_ok_o, bus.data_data_ok_o} !== ((k == 1) ? 2'b01 : 2'b00)) begin errors++; $display("FAIL flush_resp k%0d got %b want %b", k, {bus.inst_data_ok_o, bus.data_data_ok_o}, (k == 1) ? 2'b01 : 2'b00); end
    end
    step();
    idle();
  endtask

  task automatic test_write();
    step();
    bus.data_req_i = 1'b1; bus.data_wr_i = 1'b1; bus.data_wstrb_i = 4'b0011;
    bus.data_addr_i = 32'h0000_1000; bus.data_wdata_i = 32'hDEAD_BEEF;
    settle();
    checks++; if (bus.data_addr_ok_o !== 1'b1) begin errors++; $display("FAIL write_accept got %b want 1", bus.data_addr_ok_o); end
    for (int k = 1; k <= 3; k++) begin
      step();
      bus.data_wr_i = 1'b0; bus.data_wstrb_i = 4'hF;
      bus.data_addr_i = 32'h5555_0000; bus.data_wdata_i = 32'h0;
      settle();
      checks++; if ({bus.data_addr_ok_o, bus.mem_req_o, bus.mem_wr_o, bus.mem_wstrb_o} !== 7'b011_0011) begin errors++; $display("FAIL write_ctl k%0d got %b want 0110011", k, {bus.data_addr_ok_o, bus.mem_req_o, bus.mem_wr_o, bus.mem_wstrb_o}); end
      checks++; if ({bus.mem_addr_o, bus.mem_wdata_o} !== {32'h0000_1000, 32'hDEAD_BEEF}) begin errors++; $display("FAIL write_data k%0d got %h %h want 00001000 deadbeef", k, bus.mem_addr_o, bus.mem_wdata_o); end
    end
    step();
    bus.data_req_i = 1'b0;
    bus.mem_addr_ok_i = 1'b1;
    settle();
    step();
    bus.mem_addr_ok_i = 1'b0;
    settle();
    checks++; if (bus.mem_req_o !== 1'b0) begin errors++; $display("FAIL write_issued got %b want 0", bus.mem_req_o); end
    step();
    bus.mem_data_ok_i = 1'b1;
    settle();
    checks++; if ({bus.inst_data_ok_o, bus.data_data_ok_o} !== 2'b01) begin errors++; $display("FAIL write_resp got %b want 01", {bus.inst_data_ok_o, bus.data_data_ok_o}); end
    step();
    idle();
  endtask

  task automatic test_err_and_async_reset();
    step();
    bus.mem_data_ok_i = 1'b1;
    settle();
    checks++; if ({bus.inst_data_ok_o, bus.data_data_ok_o, bus.err_o} !== 3'b000) begin errors++; $display("FAIL err_stray got %b want 000", {bus.inst_data_ok_o, bus.data_data_ok_o, bus.err_o}); end
    step();
    bus.mem_data_ok_i = 1'b0;
    settle();
    checks++; if (bus.err_o !== 1'b1) begin errors++; $display("FAIL err_set got %b want 1", bus.err_o); end
    step(); settle();
    checks++; if (bus.err_o !== 1'b1) begin errors++; $display("FAIL err_sticky got %b want 1", bus.err_o); end
    step();
    bus.inst_req_i = 1'b1; bus.inst_addr_i = 32'h0000_7000;
    settle();
    checks++; if (bus.inst_addr_ok_o !== 1'b1) begin errors++; $display("FAIL err_txn_accept got %b want 1", bus.inst_addr_ok_o); end
    step();
    bus.inst_req_i = 1'b0;
    settle();
    checks++; if (bus.mem_req_o !== 1'b1) begin errors++; $display("FAIL err_txn_req got %b want 1", bus.mem_req_o); end
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if ({bus.mem_req_o, bus.mem_wr_o, bus.mem_wstrb_o, bus.err_o} !== 7'b0) begin errors++; $display("FAIL async_rst_ctl got %b want 0000000", {bus.mem_req_o, bus.mem_wr_o, bus.mem_wstrb_o, bus.err_o}); end
    checks++; if (bus.mem_addr_o !== 32'h0) begin errors++; $display("FAIL async_rst_addr got %h want 0", bus.mem_addr_o); end
    step();
    rst_n = 1'b1;
    step();
    bus.mem_data_ok_i = 1'b1;
    settle();
    checks++; if ({bus.inst_data_ok_o, bus.data_data_ok_o} !== 2'b00) begin errors++; $display("FAIL post_rst_resp got %b want 00", {bus.inst_data_ok_o, bus.data_data_ok_o}); end
    step();
    bus.mem_data_ok_i = 1'b0;
    settle();
    checks++; if (bus.err_o !== 1'b1) begin errors++; $display("FAIL post_rst_err got %b want 1", bus.err_o); end
  endtask

  initial begin
    test_reset();
    test_single_inst();
    test_starvation();
    test_stall_and_credit();
    test_flush();
    test_write();
    test_err_and_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
